counter_bank: RTL

- Parametrised successor to the fixed 128-entry free-running counter array: DEPTH independent WIDTH-bit event counters stored as an indexed array.
- One increment port per cycle with a variable step.
- Registered read port with optional read-and-clear.
- Storage is cleared by a hardware sweep state machine rather than a single-cycle loop, so the array can map to RAM. Used as the statistics/event-count block for game logic (hits, scores, timers).

---
 rtl/counter_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/counter_bank.sv
// counter_bank: DEPTH x WIDTH event counters, stepped increment, read/clear port.
// Build option COUNTER_BANK_SATURATE_EN: saturate on overflow instead of wrapping.

module counter_bank #(
   parameter int DEPTH  = 128,
   parameter int WIDTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int STEP_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear_all,
   output logic              busy,
   input  logic              inc_valid,
   input  logic [IDX_W-1:0]  inc_idx,
   input  logic [STEP_W-1:0] inc_amt,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic              rd_clear,
   output logic              rd_valid,
   output logic [WIDTH-1:0]  rd_data,
   output logic              overflow,
   output logic [IDX_W-1:0]  overflow_idx
);

   typedef enum logic {CLEAR, IDLE} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0]   rd_data_q, rd_data_d;
   logic               overflow_q, overflow_d;
   logic [IDX_W-1:0]   ovf_idx_q, ovf_idx_d;

   logic [WIDTH-1:0]   cnt_mem [DEPTH];

   logic               accept, inc_ok, rd_ok, inc_we, clr_we;
   logic [IDX_W-1:0]   clr_addr;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   inc_cur, inc_new, rd_cur;

   always_comb begin
      accept  = (state_q == IDLE);
      inc_ok  = 32'(inc_idx) < 32'(DEPTH);
      rd_ok   = 32'(rd_idx) < 32'(DEPTH);
      inc_we  = accept && inc_valid && inc_ok;
      inc_cur = inc_ok ? cnt_mem[inc_idx] : '0;
      sum     = {1'b0, inc_cur} + (WIDTH+1)'(inc_amt);
`ifdef COUNTER_BANK_SATURATE_EN
      inc_new = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
      inc_new = sum[WIDTH-1:0];
`endif
      // same-edge increment is forwarded into the read result
      rd_cur = rd_ok ? cnt_mem[rd_idx] : '0;
      if (inc_we && (inc_idx == rd_idx)) begin
         rd_cur = inc_new;
      end
      clr_we   = !accept || (rd_en && rd_clear && rd_ok);
      clr_addr = accept ? rd_idx : ptr_q;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         CLEAR: begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(DEPTH - 1)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         IDLE: begin
            if (clear_all) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_valid_d = accept && rd_en;
      rd_data_d  = rd_data_q;
      if (rd_valid_d) begin
         rd_data_d = rd_cur;
      end
      overflow_d = inc_we && sum[WIDTH];
      ovf_idx_d  = overflow_d ? inc_idx : ovf_idx_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= CLEAR;
         ptr_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         overflow_q <= 1'b0;
         ovf_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         overflow_q <= overflow_d;
         ovf_idx_q  <= ovf_idx_d;
      end
   end

   // clear write lands after the increment so read-and-clear leaves zero
   always_ff @(posedge clock) begin
      if (inc_we) begin
         cnt_mem[inc_idx] <= inc_new;
      end
      if (clr_we) begin
         cnt_mem[clr_addr] <= '0;
      end
   end

   assign busy         = (state_q == CLEAR);
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign overflow     = overflow_q;
   assign overflow_idx = ovf_idx_q;

endmodule
